multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control sequencer for the RISC-V core. It replaces the single-cycle main decoder when instruction memory and data memory are one shared port and one shared ALU. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath mux selects, write strobes and ALU op class, and stalls on a memory-ready handshake.

## Interface
- No parameters.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_op  in  7  opcode from the instruction register; valid from DECODE onward.
- i_mem_ready  in  1  shared memory port completes the current access this cycle.
- o_mem_req  out  1  memory access request.
- o_adr_src  out  1  0 = PC, 1 = ALUOut drives the memory address.
- o_mem_write  out  1  store strobe.
- o_ir_write  out  1  loads the instruction register and the oldPC register.
- o_pc_update  out  1  unconditional PC write.
- o_branch  out  1  PC write qualified by ALU zero.
- o_reg_write  out  1  register-file write.
- o_result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- o_alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1.
- o_alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- o_alu_op  out  2  00 add, 01 sub/compare, 10 decode by funct.
- o_imm_src  out  2  immediate format.
- o_state  out  4  current state, for debug.
- o_illegal  out  1  one-cycle pulse on an unsupported opcode.

## Operation
State encodings are fixed as follows:
- IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMREAD = 4, MEMWB = 5, MEMWRITE = 6.
- EXECR = 7, EXECI = 8, ALUWB = 9, JAL = 10, BEQ = 11, JALR = 12, JALRLNK = 13.

Any output not listed for a state is 0. Those outputs are:
- IDLE: none. Next state is FETCH.
- FETCH: mem_req = 1, adr_src = 0, src_a = 00, src_b = 10, alu_op = 00, result_src = 10.
  - ir_write and pc_update equal i_mem_ready.
  - Stays in FETCH while i_mem_ready = 0. Moves to DECODE when it is 1.
- DECODE: src_a = 01, src_b = 01, alu_op = 00. The branch or JAL target is captured in ALUOut. Dispatch on i_op:
  - 3 or 35 → MEMADR.
  - 51 → EXECR.
  - 19 → EXECI.
  - 111 → JAL.
  - 99 → BEQ.
  - 103 → JALR.
  - Any other opcode → FETCH with o_illegal = 1.
- MEMADR: src_a = 10, src_b = 01, alu_op = 00. Opcode 3 → MEMREAD; opcode 35 → MEMWRITE.
- MEMREAD: mem_req = 1, adr_src = 1. Holds until i_mem_ready, then → MEMWB.
- MEMWB: result_src = 01, reg_write = 1. Next state is FETCH.
- MEMWRITE: mem_req = 1, adr_src = 1, mem_write = 1. mem_write stays high every cycle until i_mem_ready, then → FETCH.
- EXECR: src_a = 10, src_b = 00, alu_op = 10. Next state is ALUWB.
- EXECI: src_a = 10, src_b = 01, alu_op = 10. Next state is ALUWB.
- ALUWB: result_src = 00, reg_write = 1. Next state is FETCH.
- JAL: src_a = 01, src_b = 10, alu_op = 00, result_src = 00, pc_update = 1. Next state is ALUWB, which writes rd = oldPC + 4.
- BEQ: src_a = 10, src_b = 00, alu_op = 01, result_src = 00, branch = 1. Next state is FETCH.
- JALR: src_a = 10, src_b = 01, alu_op = 00, result_src = 10, pc_update = 1, so PC = rs1 + imm. Next state is JALRLNK.
- JALRLNK: src_a = 01, src_b = 10, alu_op = 00. Next state is ALUWB.
- Unused encodings 14 and 15 → IDLE, with all outputs 0.

o_imm_src is combinational from i_op in every state:
- 3, 19, 103 → 00.
- 35 → 01.
- 99 → 10.
- 111 → 11.
- All other opcodes → 00.

## Timing
- Reset: the state is IDLE asynchronously. Every output is 0, except o_imm_src, which follows i_op. o_state = 0.
- The first FETCH occurs in the first cycle after reset is released.
- Instruction latency with zero wait states (i_mem_ready held at 1), in cycles:
  - BEQ: 3.
  - R-type, I-type, JAL, SW: 4.
  - LW, JALR: 5.
  - Illegal opcode: 2.
- Each cycle i_mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- All strobes except FETCH's ir_write and pc_update are Moore outputs (depend on state only). FETCH's two strobes are Mealy on i_mem_ready.
- i_mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset asserted in any state, including mid-stall, returns the FSM to IDLE immediately. No strobe is asserted after reset is asserted.

## Configuration
- JALR_EN defined: opcode 103 dispatches to JALR, then JALRLNK.
- JALR_EN undefined: the JALR and JALRLNK states are not built. Opcode 103 takes the illegal path (o_illegal pulse, → FETCH). o_imm_src for opcode 103 is still 00.

## Test plan
- Reset release with i_mem_ready = 1:
  - o_state goes 0 → 1.
  - ir_write = 1 and pc_update = 1 in the FETCH cycle.
  - Every output is 0 during reset.
- Opcode 51, zero wait states:
  - State sequence is 1, 2, 7, 9, 1.
  - reg_write = 1 only in state 9, with result_src = 00.
- Opcode 3, with i_mem_ready low for 2 cycles in MEMREAD:
  - State sequence is 1, 2, 3, 4, 4, 4, 5, 1.
  - reg_write = 1 in state 5, with result_src = 01.
- Opcode 35, with i_mem_ready low for 3 cycles in MEMWRITE:
  - mem_write = 1 for 4 consecutive cycles.
  - The FSM leaves MEMWRITE on the ready cycle.
- Opcode 0x7F:
  - o_illegal pulses for exactly 1 cycle in DECODE. Next state is FETCH.
- Opcode 103:
  - With JALR_EN defined: state sequence is 12, 13, 9. pc_update = 1 with result_src = 10 in state 12.
  - With JALR_EN undefined: o_illegal pulses in DECODE. Next state is FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the datapath.
// Carries the opcode and memory-ready inputs plus every strobe and select
// the sequencer drives.
//   master : sequencer side (reads i_op / i_mem_ready, drives o_*)
//   slave  : datapath side (drives i_op / i_mem_ready, reads o_*)
interface multicycle_ctrl_if;
    logic [6:0] i_op;
    logic       i_mem_ready;
    logic       o_mem_req;
    logic       o_adr_src;
    logic       o_mem_write;
    logic       o_ir_write;
    logic       o_pc_update;
    logic       o_branch;
    logic       o_reg_write;
    logic [1:0] o_result_src;
    logic [1:0] o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_alu_op;
    logic [1:0] o_imm_src;
    logic [3:0] o_state;
    logic       o_illegal;

    modport master (
        input  i_op, i_mem_ready,
        output o_mem_req, o_adr_src, o_mem_write, o_ir_write,
        output o_pc_update, o_branch, o_reg_write, o_result_src,
        output o_alu_src_a, o_alu_src_b, o_alu_op, o_imm_src,
        output o_state, o_illegal
    );

    modport slave (
        output i_op, i_mem_ready,
        input  o_mem_req, o_adr_src, o_mem_write, o_ir_write,
        input  o_pc_update, o_branch, o_reg_write, o_result_src,
        input  o_alu_src_a, o_alu_src_b, o_alu_op, o_imm_src,
        input  o_state, o_illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: Moore FSM stepping each instruction
// through fetch/decode/execute/memory/writeback over a shared memory port.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : multicycle_ctrl_if.master (opcode, mem ready, all strobes)
// Build option: define JALR_EN to build the JALR / JALRLNK states;
// otherwise opcode 103 is treated as illegal.
module multicycle_ctrl (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    multicycle_ctrl_if.master      bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_JAL      = 4'd10,
        S_BEQ      = 4'd11,
        S_JALR     = 4'd12,
        S_JALRLNK  = 4'd13
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_RTYPE = 7'd51;
    localparam logic [6:0] OP_ITYPE = 7'd19;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_BEQ   = 7'd99;
    localparam logic [6:0] OP_JALR  = 7'd103;

    state_e     state_q;
    state_e     state_d;

    logic [6:0] op;
    logic       mem_ready;

    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal;

    assign op        = bus.i_op;
    assign mem_ready = bus.i_mem_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC + 4 computed on the ALU while the fetch is in flight;
                // IR and PC only commit on the cycle memory completes.
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // oldPC + imm lands in ALUOut as the branch/JAL target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                unique case (1'b1)
                    (op == OP_LOAD),
                    (op == OP_STORE): state_d = S_MEMADR;
                    (op == OP_RTYPE): state_d = S_EXECR;
                    (op == OP_ITYPE): state_d = S_EXECI;
                    (op == OP_JAL):   state_d = S_JAL;
                    (op == OP_BEQ):   state_d = S_BEQ;
`ifdef JALR_EN
                    (op == OP_JALR):  state_d = S_JALR;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else if (op == OP_STORE) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // PC <- target held in ALUOut; ALU forms oldPC + 4 for rd.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef JALR_EN
            S_JALR: begin
                // PC <- rs1 + imm straight off the ALU.
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_update  = 1'b1;
                state_d    = S_JALRLNK;
            end
            S_JALRLNK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = S_ALUWB;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Immediate format follows the opcode in every state, including reset.
    always_comb begin
        imm_src = 2'b00;
        unique case (1'b1)
            (op == OP_STORE): imm_src = 2'b01;
            (op == OP_BEQ):   imm_src = 2'b10;
            (op == OP_JAL):   imm_src = 2'b11;
            default:          imm_src = 2'b00;
        endcase
    end

    assign bus.o_mem_req    = mem_req;
    assign bus.o_adr_src    = adr_src;
    assign bus.o_mem_write  = mem_write;
    assign bus.o_ir_write   = ir_write;
    assign bus.o_pc_update  = pc_update;
    assign bus.o_branch     = branch;
    assign bus.o_reg_write  = reg_write;
    assign bus.o_result_src = result_src;
    assign bus.o_alu_src_a  = alu_src_a;
    assign bus.o_alu_src_b  = alu_src_b;
    assign bus.o_alu_op     = alu_op;
    assign bus.o_imm_src    = imm_src;
    assign bus.o_state      = state_q;
    assign bus.o_illegal    = illegal;

endmodule
